axis_slave_fifo: RTL

Parametrised AXI-Stream slave that buffers incoming beats in an internal FIFO and presents them to a backend consumer over a valid/ready interface. It generalises the single-register slave front-end in data, strobe and user width and in buffer depth. It adds two things the earlier block lacks: standard backpressure in both directions and an optional store-and-forward mode that releases data only once a whole packet is buffered. It sits between the AXIS fabric and a user backend.

---
 rtl/axis_slave_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/axis_slave_fifo.sv
// AXI-Stream slave front-end: buffers beats in a circular FIFO and hands them to a
// backend over valid/ready, optionally holding data until a whole packet is stored.
module axis_slave_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 2,
  parameter int unsigned DEPTH      = 8,
  parameter bit          STORE_FWD  = 1'b0,
  localparam int unsigned StrbWidth  = DATA_WIDTH / 8,
  localparam int unsigned PtrWidth   = $clog2(DEPTH),
  localparam int unsigned LvlWidth   = $clog2(DEPTH + 1),
  localparam int unsigned EntryWidth = DATA_WIDTH + 2 * StrbWidth + USER_WIDTH + 1
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic                  axis_tvalid,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  input  logic [StrbWidth-1:0]  axis_tstrb,
  input  logic [StrbWidth-1:0]  axis_tkeep,
  input  logic [USER_WIDTH-1:0] axis_tuser,
  input  logic                  axis_tlast,
  output logic                  axis_tready,
  output logic [DATA_WIDTH-1:0] bk_data,
  output logic [StrbWidth-1:0]  bk_tstrb,
  output logic [StrbWidth-1:0]  bk_tkeep,
  output logic [USER_WIDTH-1:0] bk_user,
  output logic                  bk_tlast,
  output logic                  bk_valid,
  input  logic                  bk_ready,
  output logic [LvlWidth-1:0]   fifo_level,
  output logic [LvlWidth-1:0]   pkt_count
);

  logic [EntryWidth-1:0] mem_q [DEPTH];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlWidth-1:0]   level_q, level_d, pkt_q, pkt_d;
  logic                  fallback_q, fallback_d;
  logic [EntryWidth-1:0] head;
  logic                  head_last, full, wr_en, rd_en, wr_last, rd_last;

  assign full        = (level_q == LvlWidth'(DEPTH));
  assign axis_tready = !axi_areset && !full;
  assign head        = mem_q[rd_ptr_q];
  assign head_last   = head[0];

  // Full FIFO or an already-started partial packet releases data without a stored tlast.
  always_comb begin
    if (STORE_FWD) begin
      bk_valid = (level_q != '0) && ((pkt_q != '0) || full || fallback_q);
    end else begin
      bk_valid = (level_q != '0);
    end
  end

  assign wr_en   = axis_tvalid && axis_tready;
  assign rd_en   = bk_valid && bk_ready;
  assign wr_last = wr_en && axis_tlast;
  assign rd_last = rd_en && head_last;

  assign {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast} = bk_valid ? head : '0;
  assign fifo_level = level_q;
  assign pkt_count  = pkt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pkt_d      = pkt_q;
    fallback_d = fallback_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LvlWidth'(1);
      2'b01:   level_d = level_q - LvlWidth'(1);
      default: level_d = level_q;
    endcase
    if (wr_last && !rd_last) begin
      pkt_d = pkt_q + LvlWidth'(1);
    end else if (rd_last && !wr_last) begin
      pkt_d = pkt_q - LvlWidth'(1);
    end
    // Popping a beat with no complete packet stored means the head packet is in cut-through.
    if (rd_en) fallback_d = STORE_FWD && !head_last && ((pkt_q == '0) || fallback_q);
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_q      <= '0;
      fallback_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_q      <= pkt_d;
      fallback_q <= fallback_d;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast};
    end
  end

endmodule
